// File: rtl/async_fifo_param.sv
// Dual-clock FIFO with Gray-coded pointer crossing, registered read data, per-domain fill counts
// and almost flags. Define FIFO_ERR_FLAGS_EN to enable the sticky overflow/underflow flags.
module async_fifo_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  logic              wclk,
  input  logic              rclk,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_count,
  input  logic              ovf_clr,
  output logic              overflow,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   rd_count,
  input  logic              udf_clr,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int AF_INT = AF_LEVEL;
  localparam int AE_INT = AE_LEVEL;
  localparam logic [ADDR_W:0] AF_LVL = AF_INT[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_LVL = AE_INT[ADDR_W:0];

  function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
    logic [ADDR_W:0] b;
    b[ADDR_W] = g[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0] wbin;
  logic [ADDR_W:0] wgray;
  logic [ADDR_W:0] rgray_q1;
  logic [ADDR_W:0] rgray_q2;
  logic [ADDR_W:0] wbin_next;
  logic [ADDR_W:0] wgray_next;
  logic [ADDR_W:0] wr_count_next;
  logic            full_next;
  logic            wr_accept;

  logic [ADDR_W:0] rbin;
  logic [ADDR_W:0] rgray;
  logic [ADDR_W:0] wgray_q1;
  logic [ADDR_W:0] wgray_q2;
  logic [ADDR_W:0] rbin_next;
  logic [ADDR_W:0] rgray_next;
  logic [ADDR_W:0] rd_count_next;
  logic            empty_next;
  logic            rd_accept;

  // Flags and counts are all derived from the post-increment pointer so they agree on every edge.
  always_comb begin
    wr_accept     = wr_en && !full;
    wbin_next     = wbin + {{ADDR_W{1'b0}}, wr_accept};
    wgray_next    = bin2gray(wbin_next);
    full_next     = (wgray_next == {~rgray_q2[ADDR_W:ADDR_W-1], rgray_q2[ADDR_W-2:0]});
    wr_count_next = wbin_next - gray2bin(rgray_q2);
  end

  always_ff @(posedge wclk or negedge resetn) begin
    if (!resetn) begin
      wbin        <= '0;
      wgray       <= '0;
      rgray_q1    <= '0;
      rgray_q2    <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_count    <= '0;
    end else begin
      rgray_q1    <= rgray;
      rgray_q2    <= rgray_q1;
      wbin        <= wbin_next;
      wgray       <= wgray_next;
      full        <= full_next;
      almost_full <= (wr_count_next >= AF_LVL);
      wr_count    <= wr_count_next;
    end
  end

  always_ff @(posedge wclk) begin
    if (wr_accept) begin
      mem[wbin[ADDR_W-1:0]] <= wr_data;
    end
  end

  always_comb begin
    rd_accept     = rd_en && !empty;
    rbin_next     = rbin + {{ADDR_W{1'b0}}, rd_accept};
    rgray_next    = bin2gray(rbin_next);
    empty_next    = (rgray_next == wgray_q2);
    rd_count_next = gray2bin(wgray_q2) - rbin_next;
  end

  // The entry is only read once the synchronised write pointer shows it, so it is stable here.
  always_ff @(posedge rclk or negedge resetn) begin
    if (!resetn) begin
      rbin         <= '0;
      rgray        <= '0;
      wgray_q1     <= '0;
      wgray_q2     <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_count     <= '0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
    end else begin
      wgray_q1     <= wgray;
      wgray_q2     <= wgray_q1;
      rbin         <= rbin_next;
      rgray        <= rgray_next;
      empty        <= empty_next;
      almost_empty <= (rd_count_next <= AE_LVL);
      rd_count     <= rd_count_next;
      rd_valid     <= rd_accept;
      if (rd_accept) begin
        rd_data <= mem[rbin[ADDR_W-1:0]];
      end
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  // A new error on the same edge as a clear wins, so no event is ever lost.
  always_ff @(posedge wclk or negedge resetn) begin
    if (!resetn) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge rclk or negedge resetn) begin
    if (!resetn) begin
      underflow <= 1'b0;
    end else if (rd_en && empty) begin
      underflow <= 1'b1;
    end else if (udf_clr) begin
      underflow <= 1'b0;
    end
  end
`else
  logic unused_clr;
  assign unused_clr = ovf_clr ^ udf_clr;
  assign overflow   = 1'b0;
  assign underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_async_fifo_param.sv
// Scoreboard bench for async_fifo_param: directed fill/drain, latency, almost flags, error flags,
// mid-operation reset and randomised concurrent traffic under both clock-ratio orders.
`timescale 1ns/100ps
module tb_async_fifo_param;

`ifdef FIFO_ERR_FLAGS_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        wclk = 1'b0;
  logic        rclk = 1'b0;
  logic        resetn;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        full;
  logic        almost_full;
  logic [4:0]  wr_count;
  logic        ovf_clr;
  logic        overflow;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        empty;
  logic        almost_empty;
  logic [4:0]  rd_count;
  logic        udf_clr;
  logic        underflow;

  realtime w_half = 5.0;
  realtime r_half = 13.5;

  int tests = 0;
  int failures = 0;
  int rx_count = 0;
  int viol = 0;
  logic [31:0] sb [$];
  logic [31:0] exp_word;

  always #(w_half) wclk = ~wclk;
  always #(r_half) rclk = ~rclk;

  async_fifo_param dut (
    .wclk(wclk), .rclk(rclk), .resetn(resetn),
    .wr_en(wr_en), .wr_data(wr_data), .full(full), .almost_full(almost_full),
    .wr_count(wr_count), .ovf_clr(ovf_clr), .overflow(overflow),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
    .almost_empty(almost_empty), .rd_count(rd_count), .udf_clr(udf_clr), .underflow(underflow)
  );

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr_edge();
    @(posedge wclk);
    #1;
  endtask

  task automatic rd_edge();
    @(posedge rclk);
    #1;
  endtask

  // One write cycle; accept says whether the FIFO is expected to take the word.
  task automatic apply_stimulus(input logic [31:0] data, input bit accept);
    wr_en = 1'b1;
    wr_data = data;
    if (accept) sb.push_back(data);
    wr_edge();
    wr_en = 1'b0;
  endtask

  task automatic read_words(input int n);
    int got = 0;
    int cyc = 0;
    rd_edge();
    while (got < n && cyc < 200) begin
      rd_en = !empty;
      if (!empty) got++;
      rd_edge();
      cyc++;
    end
    rd_en = 1'b0;
    if (got < n) check_output("read_words_timeout", got, n);
  endtask

  task automatic run_traffic(input int n);
    int target;
    target = rx_count + n;
    viol = 0;
    fork
      begin
        int sent = 0;
        int cyc = 0;
        while (sent < n && cyc < 20000) begin
          wr_edge();
          cyc++;
          if (wr_count > 5'd16) viol++;
          if (!full && $urandom_range(3) != 0) begin
            wr_en = 1'b1;
            wr_data = $urandom;
            sb.push_back(wr_data);
            sent++;
          end else begin
            wr_en = 1'b0;
          end
        end
        wr_edge();
        wr_en = 1'b0;
        if (sent < n) check_output("writer_timeout", sent, n);
      end
      begin
        int cyc = 0;
        while (rx_count < target && cyc < 40000) begin
          rd_edge();
          cyc++;
          if (rd_count > 5'd16) viol++;
          rd_en = !empty && ($urandom_range(3) != 0);
        end
        rd_en = 1'b0;
        if (rx_count < target) check_output("reader_timeout", rx_count, target);
      end
    join
    repeat (3) rd_edge();
    check_output("traffic_sb_drained", sb.size(), 0);
    check_output("traffic_count_range", viol, 0);
    check_output("traffic_overflow", overflow, 1'b0);
    check_output("traffic_underflow", underflow, 1'b0);
  endtask

  // Monitor: every presented word must be the oldest outstanding write.
  always begin
    @(posedge rclk);
    #1;
    if (rd_valid) begin
      rx_count++;
      if (sb.size() == 0) begin
        tests++;
        failures++;
        $display("[TB] FAIL rd_unexpected: got 0x%0h, expected no data", rd_data);
      end else begin
        exp_word = sb.pop_front();
        check_output("rd_data", rd_data, exp_word);
      end
    end
  end

  initial begin
    #500000;
    tests++;
    failures++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    int edges;
    resetn = 1'b0;
    wr_en = 1'b0;
    wr_data = '0;
    rd_en = 1'b0;
    ovf_clr = 1'b0;
    udf_clr = 1'b0;
    repeat (3) @(posedge rclk);
    #1;
    check_output("rst_empty", empty, 1'b1);
    check_output("rst_almost_empty", almost_empty, 1'b1);
    check_output("rst_full", full, 1'b0);
    check_output("rst_almost_full", almost_full, 1'b0);
    check_output("rst_rd_valid", rd_valid, 1'b0);
    check_output("rst_counts", {wr_count, rd_count}, 10'd0);
    check_output("rst_rd_data", rd_data, 32'h0);
    check_output("rst_err_flags", {overflow, underflow}, 2'b00);
    resetn = 1'b1;

    // Fill with 1..16, drop a 17th, exercise overflow then drain in order.
    wr_edge();
    for (int i = 1; i <= 16; i++) apply_stimulus(32'(i), 1'b1);
    check_output("fill_full", full, 1'b1);
    check_output("fill_wr_count", wr_count, 5'd16);
    check_output("fill_almost_full", almost_full, 1'b1);
    apply_stimulus(32'h11, 1'b0);
    check_output("drop_full", full, 1'b1);
    check_output("drop_wr_count", wr_count, 5'd16);
    check_output("overflow_set", overflow, ERR_EN);
    ovf_clr = 1'b1;
    apply_stimulus(32'h12, 1'b0);
    ovf_clr = 1'b0;
    check_output("overflow_set_beats_clr", overflow, ERR_EN);
    ovf_clr = 1'b1;
    wr_edge();
    ovf_clr = 1'b0;
    check_output("overflow_cleared", overflow, 1'b0);
    read_words(16);
    repeat (3) rd_edge();
    check_output("drain_sb_empty", sb.size(), 0);
    check_output("drain_empty", empty, 1'b1);
    check_output("drain_rd_count", rd_count, 5'd0);
    rd_en = 1'b1;
    rd_edge();
    rd_en = 1'b0;
    check_output("underflow_set", underflow, ERR_EN);
    udf_clr = 1'b1;
    rd_edge();
    udf_clr = 1'b0;
    check_output("underflow_cleared", underflow, 1'b0);
    repeat (4) wr_edge();
    check_output("drain_full_clear", full, 1'b0);
    check_output("drain_wr_count", wr_count, 5'd0);

    // Single word: empty falls within 3 rclk edges, data one rclk after rd_en.
    wr_edge();
    apply_stimulus(32'hA5A5A5A5, 1'b1);
    edges = 0;
    while (empty && edges < 6) begin
      rd_edge();
      edges++;
    end
    check_output("empty_fall_latency", (edges <= 3) && !empty, 1'b1);
    rd_en = 1'b1;
    rd_edge();
    rd_en = 1'b0;
    check_output("single_rd_valid", rd_valid, 1'b1);
    check_output("single_rd_data", rd_data, 32'hA5A5A5A5);
    check_output("single_empty_again", empty, 1'b1);
    rd_edge();
    check_output("single_rd_valid_drop", rd_valid, 1'b0);

    // Almost flags at the 12-entry and 2/3-entry thresholds.
    wr_edge();
    for (int i = 0; i < 11; i++) apply_stimulus(32'h100 + 32'(i), 1'b1);
    check_output("af_11_flag", almost_full, 1'b0);
    check_output("af_11_count", wr_count, 5'd11);
    apply_stimulus(32'h10B, 1'b1);
    check_output("af_12_flag", almost_full, 1'b1);
    check_output("af_12_count", wr_count, 5'd12);
    repeat (4) rd_edge();
    check_output("ae_12_count", rd_count, 5'd12);
    check_output("ae_12_flag", almost_empty, 1'b0);
    read_words(9);
    check_output("ae_3_count", rd_count, 5'd3);
    check_output("ae_3_flag", almost_empty, 1'b0);
    read_words(1);
    check_output("ae_2_count", rd_count, 5'd2);
    check_output("ae_2_flag", almost_empty, 1'b1);
    read_words(2);

    // Reset with 9 entries stored: everything returns to idle at once.
    wr_edge();
    for (int i = 0; i < 9; i++) apply_stimulus(32'h200 + 32'(i), 1'b1);
    repeat (4) rd_edge();
    check_output("pre_reset_rd_count", rd_count, 5'd9);
    #3;
    resetn = 1'b0;
    #1;
    check_output("mid_rst_empty", empty, 1'b1);
    check_output("mid_rst_counts", {wr_count, rd_count}, 10'd0);
    check_output("mid_rst_rd_valid", rd_valid, 1'b0);
    check_output("mid_rst_full_ae", {full, almost_empty}, 2'b01);
    sb.delete();
    #5;
    resetn = 1'b1;
    wr_edge();
    apply_stimulus(32'h12345678, 1'b1);
    read_words(1);
    repeat (2) rd_edge();
    check_output("post_rst_sb_empty", sb.size(), 0);

    // Concurrent traffic, fast writer then fast reader.
    run_traffic(500);
    w_half = 13.5;
    r_half = 5.0;
    repeat (4) wr_edge();
    run_traffic(500);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
